// File: rtl/icache_flush_ctrl_if.sv
// Flush-controller connection bundle: core request, refill status, cleaning counter and tag RAM.
interface icache_flush_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAYS       = 4
);
  logic                  flush_req_i;
  logic                  refill_busy_i;
  logic [ADDR_WIDTH-1:0] clean_addr_i;
  logic                  clean_done_i;
  logic                  flush_en_o;
  logic [WAYS-1:0]       tag_we_o;
  logic [ADDR_WIDTH-1:0] tag_addr_o;
  logic                  valid_clr_o;
  logic                  icache_stall_o;
  logic                  flush_busy_o;
  logic                  flush_ack_o;
  logic                  sweep_err_o;

  modport master (
    input  flush_req_i, refill_busy_i, clean_addr_i, clean_done_i,
    output flush_en_o, tag_we_o, tag_addr_o, valid_clr_o,
           icache_stall_o, flush_busy_o, flush_ack_o, sweep_err_o
  );

  modport slave (
    output flush_req_i, refill_busy_i, clean_addr_i, clean_done_i,
    input  flush_en_o, tag_we_o, tag_addr_o, valid_clr_o,
           icache_stall_o, flush_busy_o, flush_ack_o, sweep_err_o
  );
endinterface

// File: rtl/icache_flush_ctrl.sv
// Icache flush sequencer: drains refills, sweeps every set with an all-ways invalidate, acks.
//
// state | meaning
// IDLE  | no flush in progress
// DRAIN | lookups stalled, waiting for outstanding refill to finish
// SWEEP | one set invalidated per cycle from the cleaning counter address
// DONE  | one-cycle ack; restart if another request arrived during sweep
module icache_flush_ctrl #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int WAYS       = 4
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  icache_flush_ctrl_if.master  fl
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH:0]   sweep_cnt_q;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic                  sweep_err_q;
  logic                  wd_trip;

  assign cnt_inc = sweep_cnt_q + CNT_ONE;
  // Watchdog fires on the DEPTH-th sweep cycle if the counter never signalled its last set.
  assign wd_trip = (state_q == S_SWEEP) && !fl.clean_done_i && (cnt_inc == CNT_LIMIT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      sweep_cnt_q <= '0;
      sweep_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (state_q == S_SWEEP)
        sweep_cnt_q <= cnt_inc;
      else if (state_d == S_SWEEP)
        sweep_cnt_q <= '0;
      if (wd_trip)
        sweep_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (fl.flush_req_i)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!fl.refill_busy_i)
          state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (fl.flush_req_i)
          pending_d = 1'b1;
        if (fl.clean_done_i || wd_trip)
          state_d = S_DONE;
      end
      S_DONE: begin
        // A request landing in DONE itself counts as pending for the restart decision.
        state_d   = (pending_q || fl.flush_req_i) ? S_DRAIN : S_IDLE;
        pending_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fl.flush_en_o     = 1'b0;
    fl.tag_we_o       = '0;
    fl.tag_addr_o     = '0;
    fl.valid_clr_o    = 1'b0;
    fl.icache_stall_o = 1'b0;
    fl.flush_ack_o    = 1'b0;
    fl.flush_busy_o   = (state_q != S_IDLE);
    fl.sweep_err_o    = sweep_err_q;
    case (state_q)
      S_DRAIN: fl.icache_stall_o = 1'b1;
      S_SWEEP: begin
        fl.icache_stall_o = 1'b1;
        fl.flush_en_o     = 1'b1;
        fl.valid_clr_o    = 1'b1;
        fl.tag_we_o       = '1;
        fl.tag_addr_o     = fl.clean_addr_i;
      end
      S_DONE: begin
        fl.icache_stall_o = 1'b1;
        fl.flush_ack_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_flush_ctrl.sv
// Directed bench for icache_flush_ctrl with a behavioural cleaning counter.
module tb_icache_flush_ctrl;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic tie_done0;
  logic [7:0] clean_cnt;
  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int ack_base;

  icache_flush_ctrl_if #(.ADDR_WIDTH(8), .WAYS(4)) fif ();

  icache_flush_ctrl #(.DEPTH(256), .ADDR_WIDTH(8), .WAYS(4)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .fl     (fif)
  );

  always #5 clk_i = ~clk_i;

  // Cleaning counter: shares reset, advances on flush_en, flags its last set combinationally.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) clean_cnt <= 8'd0;
    else if (fif.flush_en_o) clean_cnt <= clean_cnt + 8'd1;
  end
  assign fif.clean_addr_i = clean_cnt;
  assign fif.clean_done_i = tie_done0 ? 1'b0 : (clean_cnt == 8'd255);

  always @(posedge clk_i) if (fif.flush_ack_o) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Walks 256 SWEEP cycles from set 0; optionally pulses a request at set req_at.
  task automatic do_sweep(input string tag, input int req_at);
    for (int i = 0; i < 256; i++) begin
      fif.flush_req_i = (i == req_at);
      chk({tag, "_addr"}, 32'(fif.tag_addr_o), 32'(i));
      chk({tag, "_en"}, 32'(fif.flush_en_o), 32'd1);
      chk({tag, "_we"}, 32'(fif.tag_we_o), 32'hF);
      chk({tag, "_vclr"}, 32'(fif.valid_clr_o), 32'd1);
      step();
    end
    fif.flush_req_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    tie_done0 = 1'b0;
    fif.flush_req_i = 1'b0;
    fif.refill_busy_i = 1'b0;
    #12;
    chk("rst_busy", 32'(fif.flush_busy_o), 32'd0);
    chk("rst_stall", 32'(fif.icache_stall_o), 32'd0);
    chk("rst_en", 32'(fif.flush_en_o), 32'd0);
    chk("rst_we", 32'(fif.tag_we_o), 32'd0);
    chk("rst_ack", 32'(fif.flush_ack_o), 32'd0);
    chk("rst_err", 32'(fif.sweep_err_o), 32'd0);
    rstn_i = 1'b1;
    step();

    // 1) basic flush
    ack_base = ack_cnt;
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    chk("t1_drain_busy", 32'(fif.flush_busy_o), 32'd1);
    chk("t1_drain_stall", 32'(fif.icache_stall_o), 32'd1);
    chk("t1_drain_en", 32'(fif.flush_en_o), 32'd0);
    step();
    do_sweep("t1", -1);
    chk("t1_ack", 32'(fif.flush_ack_o), 32'd1);
    chk("t1_done_stall", 32'(fif.icache_stall_o), 32'd1);
    chk("t1_done_en", 32'(fif.flush_en_o), 32'd0);
    chk("t1_done_addr", 32'(fif.tag_addr_o), 32'd0);
    step();
    chk("t1_idle_busy", 32'(fif.flush_busy_o), 32'd0);
    chk("t1_idle_ack", 32'(fif.flush_ack_o), 32'd0);
    chk("t1_idle_stall", 32'(fif.icache_stall_o), 32'd0);
    chk("t1_acks", 32'(ack_cnt - ack_base), 32'd1);

    // 2) refill busy for 5 cycles
    ack_base = ack_cnt;
    fif.flush_req_i = 1'b1;
    fif.refill_busy_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_en", 32'(fif.flush_en_o), 32'd0);
      chk("t2_wait_stall", 32'(fif.icache_stall_o), 32'd1);
      step();
    end
    fif.refill_busy_i = 1'b0;
    chk("t2_last_drain_en", 32'(fif.flush_en_o), 32'd0);
    chk("t2_last_drain_stall", 32'(fif.icache_stall_o), 32'd1);
    step();
    do_sweep("t2", -1);
    chk("t2_ack", 32'(fif.flush_ack_o), 32'd1);
    step();
    chk("t2_idle", 32'(fif.flush_busy_o), 32'd0);
    chk("t2_acks", 32'(ack_cnt - ack_base), 32'd1);

    // 3) coalescing: req at set 100 and at DONE -> exactly one extra sweep
    ack_base = ack_cnt;
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    step();
    do_sweep("t3a", 100);
    chk("t3_ack1", 32'(fif.flush_ack_o), 32'd1);
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    chk("t3_redrain_busy", 32'(fif.flush_busy_o), 32'd1);
    chk("t3_redrain_en", 32'(fif.flush_en_o), 32'd0);
    chk("t3_redrain_ack", 32'(fif.flush_ack_o), 32'd0);
    step();
    do_sweep("t3b", -1);
    chk("t3_ack2", 32'(fif.flush_ack_o), 32'd1);
    step();
    repeat (4) step();
    chk("t3_idle", 32'(fif.flush_busy_o), 32'd0);
    chk("t3_acks", 32'(ack_cnt - ack_base), 32'd2);

    // 4) req during DRAIN absorbed; refill_busy ignored during sweep
    ack_base = ack_cnt;
    fif.flush_req_i = 1'b1;
    step();
    step();
    fif.flush_req_i = 1'b0;
    fif.refill_busy_i = 1'b1;
    do_sweep("t4", -1);
    fif.refill_busy_i = 1'b0;
    chk("t4_ack", 32'(fif.flush_ack_o), 32'd1);
    step();
    repeat (4) step();
    chk("t4_idle", 32'(fif.flush_busy_o), 32'd0);
    chk("t4_acks", 32'(ack_cnt - ack_base), 32'd1);

    // 5) watchdog
    ack_base = ack_cnt;
    tie_done0 = 1'b1;
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    step();
    for (int i = 0; i < 256; i++) begin
      chk("t5_en", 32'(fif.flush_en_o), 32'd1);
      chk("t5_err_low", 32'(fif.sweep_err_o), 32'd0);
      step();
    end
    chk("t5_err_set", 32'(fif.sweep_err_o), 32'd1);
    chk("t5_ack", 32'(fif.flush_ack_o), 32'd1);
    step();
    tie_done0 = 1'b0;
    chk("t5_idle", 32'(fif.flush_busy_o), 32'd0);
    repeat (3) step();
    chk("t5_err_sticky", 32'(fif.sweep_err_o), 32'd1);
    chk("t5_acks", 32'(ack_cnt - ack_base), 32'd1);

    // 6) reset mid-sweep at set 37
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    step();
    repeat (37) step();
    chk("t6_at37", 32'(fif.tag_addr_o), 32'd37);
    ack_base = ack_cnt;
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_en", 32'(fif.flush_en_o), 32'd0);
    chk("t6_rst_we", 32'(fif.tag_we_o), 32'd0);
    chk("t6_rst_addr", 32'(fif.tag_addr_o), 32'd0);
    chk("t6_rst_stall", 32'(fif.icache_stall_o), 32'd0);
    chk("t6_rst_busy", 32'(fif.flush_busy_o), 32'd0);
    chk("t6_rst_err", 32'(fif.sweep_err_o), 32'd0);
    #10;
    rstn_i = 1'b1;
    step();
    chk("t6_post_busy", 32'(fif.flush_busy_o), 32'd0);
    fif.flush_req_i = 1'b1;
    step();
    fif.flush_req_i = 1'b0;
    step();
    do_sweep("t6", -1);
    chk("t6_ack", 32'(fif.flush_ack_o), 32'd1);
    step();
    chk("t6_acks", 32'(ack_cnt - ack_base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
